// File: rtl/axi4_r_sender.sv
// axi4_r_sender
//   R-channel stage of the RAB read path. Forwards slave read data (m_axi4_r*)
//   to the master (s_axi4_r*) with zero latency, and for every AR burst dropped
//   by the AR stage injects a SLVERR burst of drop_len+1 beats carrying drop_id.
//   Injection only starts between forwarded bursts.
//
// Ports
//   axi4_aclk, axi4_arst        clock, asynchronous active-high reset
//   drop_push/drop_id/drop_len  dropped-AR record from the AR stage
//   drop_full                   pending-drop FIFO full (registered)
//   s_axi4_r*                   R channel toward the master
//   m_axi4_r*                   R channel from the slave
//   drop_cnt                    completed injected bursts, saturating
//                               (only with AXI4_R_SENDER_DROP_CNT_EN defined)
//
// Build option
//   AXI4_R_SENDER_DROP_CNT_EN   adds drop_cnt output and its counter
//
// state | meaning
// IDLE  | between bursts; pass through or start an injected burst
// FWD   | inside a forwarded burst; pass through until rlast handshake
// ERR   | driving SLVERR beats for the FIFO head entry
module axi4_r_sender #(
  parameter int C_AXI_ID_WIDTH    = 4,
  parameter int C_AXI_DATA_WIDTH  = 64,
  parameter int C_AXI_USER_WIDTH  = 4,
  parameter int C_DROP_FIFO_DEPTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arst,
  input  logic                        drop_push,
  input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [7:0]                  drop_len,
  output logic                        drop_full,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready
`ifdef AXI4_R_SENDER_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int PW = $clog2(C_DROP_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(C_DROP_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [C_AXI_ID_WIDTH-1:0] fifo_id  [C_DROP_FIFO_DEPTH];
  logic [7:0]                fifo_len [C_DROP_FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic                      full_q;
  logic                      fifo_empty;
  logic [7:0]                beat_cnt_q;
  logic                      err_done_q;
  logic                      pass_en;
  logic                      fwd_hs;
  logic                      push;
  logic                      pop;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign drop_full  = full_q;

  // A pop frees a slot in the same cycle, so a push while full is still
  // accepted when the head burst completes.
  assign pop  = (state_q == ST_ERR) && s_axi4_rready && (beat_cnt_q == 8'd0);
  assign push = drop_push && (!full_q || pop);

  // err_done lets one waiting downstream burst through before the next injection.
  assign pass_en = (state_q == ST_FWD) ||
                   ((state_q == ST_IDLE) && ((err_done_q && m_axi4_rvalid) || fifo_empty));
  assign fwd_hs  = pass_en && m_axi4_rvalid && s_axi4_rready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      full_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_d;
      full_q     <= (fifo_cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      fifo_id[wr_ptr_q]  <= drop_id;
      fifo_len[wr_ptr_q] <= drop_len;
    end
  end

  // State register
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!pass_en)    state_d = ST_ERR;
        else if (fwd_hs) state_d = m_axi4_rlast ? ST_IDLE : ST_FWD;
      end
      ST_FWD:  if (fwd_hs && m_axi4_rlast) state_d = ST_IDLE;
      ST_ERR:  if (pop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_axi4_rid    = '0;
    s_axi4_rdata  = '0;
    s_axi4_rresp  = 2'b00;
    s_axi4_rlast  = 1'b0;
    s_axi4_ruser  = '0;
    s_axi4_rvalid = 1'b0;
    m_axi4_rready = 1'b0;
    if (pass_en) begin
      s_axi4_rid    = m_axi4_rid;
      s_axi4_rdata  = m_axi4_rdata;
      s_axi4_rresp  = m_axi4_rresp;
      s_axi4_rlast  = m_axi4_rlast;
      s_axi4_ruser  = m_axi4_ruser;
      s_axi4_rvalid = m_axi4_rvalid;
      m_axi4_rready = s_axi4_rready;
    end else if (state_q == ST_ERR) begin
      s_axi4_rid    = fifo_id[rd_ptr_q];
      s_axi4_rresp  = 2'b10;
      s_axi4_rlast  = (beat_cnt_q == 8'd0);
      s_axi4_rvalid = 1'b1;
    end
    if (axi4_arst) begin
      s_axi4_rvalid = 1'b0;
      m_axi4_rready = 1'b0;
    end
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      beat_cnt_q <= 8'd0;
      err_done_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && (state_d == ST_ERR))
        beat_cnt_q <= fifo_len[rd_ptr_q];
      else if ((state_q == ST_ERR) && s_axi4_rready && (beat_cnt_q != 8'd0))
        beat_cnt_q <= beat_cnt_q - 8'd1;
      if (pop)         err_done_q <= 1'b1;
      else if (fwd_hs) err_done_q <= 1'b0;
    end
  end

`ifdef AXI4_R_SENDER_DROP_CNT_EN
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst)                         drop_cnt <= 16'd0;
    else if (pop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
